video_tile_renderer: RTL and testbench

VIDEO_TILE_RENDERER -- requirements
Module: video_tile_renderer

---
 rtl/video_pkg.sv | 42 ++++
 rtl/video_timing_gen.sv | 78 +++++++
 rtl/video_tile_renderer.sv | 221 ++++++++++++++++++++++
 tb/tb_video_tile_renderer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video definitions: timing-total helper and the default
//               panel totals, the region-class encoding, the per-pixel control
//               word carried down the render pipeline, and colour constants.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Sum of the four segments of a line or a frame (sync, back porch,
    // active, front porch). Evaluated at elaboration only.
    function automatic int video_total(input int sync_len, input int bp_len,
                                       input int act_len, input int fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction

    localparam int c_def_h_total = video_total(41, 2, 480, 2);   // 525
    localparam int c_def_v_total = video_total(10, 2, 272, 2);   // 286

    // Region class of a pixel, evaluated once at stage 0.
    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_BORDER = 2'd1,
        REG_GRID   = 2'd2
    } region_t;

    // Per-pixel control carried alongside the tile read. Syncs travel as
    // "asserted" flags so an all-zero (cleared) stage is always idle.
    typedef struct packed {
        logic    hs_on;
        logic    vs_on;
        logic    de;
        logic    fs;
        region_t region;
        logic    tile_edge;
    } pix_ctl_t;

    localparam logic [23:0] c_rgb_black = 24'h000000;

endpackage
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Line/frame counter with stage-0 sync, active-window and
//               frame-origin flags. Line order is sync, back porch, active,
//               front porch. Counters hold at 0 while i_en is low.
// Ports       : clk, rst (async, active-high), i_en
//               o_h_cnt / o_v_cnt  registered counters
//               o_hs_on / o_vs_on  sync asserted (polarity applied by user)
//               o_active           inside the active window
//               o_frame_start      counters at (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs_on,
    output logic             o_vs_on,
    output logic             o_active,
    output logic             o_frame_start
);

    localparam int c_h_total = video_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int c_v_total = video_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int c_h_act0  = H_SYNC + H_BP;
    localparam int c_h_act1  = c_h_act0 + H_ACTIVE;
    localparam int c_v_act0  = V_SYNC + V_BP;
    localparam int c_v_act1  = c_v_act0 + V_ACTIVE;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h_cnt == CNT_W'(c_h_total - 1));
    assign w_v_wrap = (r_v_cnt == CNT_W'(c_v_total - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_hs_on       = i_en && (r_h_cnt < CNT_W'(H_SYNC));
    assign o_vs_on       = i_en && (r_v_cnt < CNT_W'(V_SYNC));
    assign o_active      = i_en
                           && (r_h_cnt >= CNT_W'(c_h_act0)) && (r_h_cnt < CNT_W'(c_h_act1))
                           && (r_v_cnt >= CNT_W'(c_v_act0)) && (r_v_cnt < CNT_W'(c_v_act1));
    assign o_frame_start = i_en && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/video_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : video_tile_renderer
// Description : Renders a 1-bit tile map as a coloured grid with an optional
//               per-tile outline and a border ring, on top of the timing
//               generator. Tile reads are issued one cycle after the counter;
//               tile_bit is sampled RD_LAT clock edges after the edge that
//               launches tile_rd_en, so all outputs land RD_LAT+1 cycles
//               after the counter value that produced them.
// Ports       : clk, rst (async, active-high), en, outline_en
//               fg_rgb/bg_rgb/border_rgb/outline_rgb  colour inputs {R,G,B}
//               tile_rd_en, tile_col, tile_row        tile read request
//               tile_bit                              tile read data
//               hs, vs, de, rgb, frame_start          video out
// Revision    : 1.0 - initial release
// ============================================================================
module video_tile_renderer
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = 480,
    parameter int H_FP      = 2,
    parameter int H_SYNC    = 41,
    parameter int H_BP      = 2,
    parameter int V_ACTIVE  = 272,
    parameter int V_FP      = 2,
    parameter int V_SYNC    = 10,
    parameter int V_BP      = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 12,
    parameter int TILE_LOG2 = 4,
    parameter int GRID_X0   = 16,
    parameter int GRID_Y0   = 16,
    parameter int GRID_COLS = 28,
    parameter int GRID_ROWS = 15,
    parameter int BORDER_W  = 2,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             outline_en,
    input  logic [23:0]      fg_rgb,
    input  logic [23:0]      bg_rgb,
    input  logic [23:0]      border_rgb,
    input  logic [23:0]      outline_rgb,
    output logic             tile_rd_en,
    output logic [CNT_W-1:0] tile_col,
    output logic [CNT_W-1:0] tile_row,
    input  logic             tile_bit,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [23:0]      rgb,
    output logic             frame_start
);

    localparam int c_h_start = H_SYNC + H_BP;
    localparam int c_v_start = V_SYNC + V_BP;
    localparam int c_gx1     = GRID_X0 + (GRID_COLS << TILE_LOG2);
    localparam int c_gy1     = GRID_Y0 + (GRID_ROWS << TILE_LOG2);
    localparam int c_bx0     = GRID_X0 - BORDER_W;
    localparam int c_by0     = GRID_Y0 - BORDER_W;
    localparam int c_bx1     = c_gx1 + BORDER_W;
    localparam int c_by1     = c_gy1 + BORDER_W;

    // ---------------------------------------------------------------- stage 0
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_active;
    logic             w_fs;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .i_en          (en),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_hs_on       (w_hs_on),
        .o_vs_on       (w_vs_on),
        .o_active      (w_active),
        .o_frame_start (w_fs)
    );

    int       w_ax;
    int       w_ay;
    int       w_gx;
    int       w_gy;
    logic     w_in_grid;
    logic     w_in_border;
    pix_ctl_t w_ctl0;

    // Grid and border tests are gated by the active window, which clips any
    // part of them lying beyond H_ACTIVE / V_ACTIVE.
    always_comb begin
        w_ax        = int'(w_h_cnt) - c_h_start;
        w_ay        = int'(w_v_cnt) - c_v_start;
        w_gx        = w_ax - GRID_X0;
        w_gy        = w_ay - GRID_Y0;
        w_in_grid   = w_active && (w_ax >= GRID_X0) && (w_ax < c_gx1)
                                && (w_ay >= GRID_Y0) && (w_ay < c_gy1);
        w_in_border = w_active && !w_in_grid
                      && (w_ax >= c_bx0) && (w_ax < c_bx1)
                      && (w_ay >= c_by0) && (w_ay < c_by1);
        w_ctl0.hs_on     = w_hs_on;
        w_ctl0.vs_on     = w_vs_on;
        w_ctl0.de        = w_active;
        w_ctl0.fs        = w_fs;
        w_ctl0.region    = w_in_grid ? REG_GRID : (w_in_border ? REG_BORDER : REG_NONE);
        w_ctl0.tile_edge = (w_gx[TILE_LOG2-1:0] == '0) || (w_gx[TILE_LOG2-1:0] == '1)
                        || (w_gy[TILE_LOG2-1:0] == '0) || (w_gy[TILE_LOG2-1:0] == '1);
    end

    // ---------------------------------------------------- stage 1: tile read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_rd_en <= 1'b0;
            tile_col   <= '0;
            tile_row   <= '0;
        end else if (!en) begin
            tile_rd_en <= 1'b0;
        end else begin
            tile_rd_en <= w_in_grid;
            if (w_in_grid) begin
                tile_col <= CNT_W'(w_gx >>> TILE_LOG2);
                tile_row <= CNT_W'(w_gy >>> TILE_LOG2);
            end
        end
    end

    // ------------------------------------- control pipeline, stages 1..RD_LAT
    pix_ctl_t r_pipe [1:RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= '0;
        end else if (!en) begin
            for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[1] <= w_ctl0;
            for (int i = 2; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // ------------------------------------------------------- colour shadows
    // Reloaded only at the frame origin, well before the first active pixel
    // and after the last one of the previous frame has left the pipeline.
    logic [23:0] r_fg_rgb;
    logic [23:0] r_bg_rgb;
    logic [23:0] r_border_rgb;
    logic [23:0] r_outline_rgb;
    logic        r_outline_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fg_rgb      <= c_rgb_black;
            r_bg_rgb      <= c_rgb_black;
            r_border_rgb  <= c_rgb_black;
            r_outline_rgb <= c_rgb_black;
            r_outline_en  <= 1'b0;
        end else if ((w_h_cnt == '0) && (w_v_cnt == '0)) begin
            r_fg_rgb      <= fg_rgb;
            r_bg_rgb      <= bg_rgb;
            r_border_rgb  <= border_rgb;
            r_outline_rgb <= outline_rgb;
            r_outline_en  <= outline_en;
        end
    end

    // ---------------------------------------------------------- output stage
    pix_ctl_t    w_out_ctl;
    logic [23:0] w_rgb;

    assign w_out_ctl = r_pipe[RD_LAT];

    always_comb begin
        w_rgb = c_rgb_black;
        if (w_out_ctl.de) begin
            case (w_out_ctl.region)
                REG_GRID: begin
                    if (tile_bit)
                        w_rgb = (r_outline_en && w_out_ctl.tile_edge) ? r_outline_rgb : r_fg_rgb;
                    else
                        w_rgb = r_bg_rgb;
                end
                REG_BORDER: w_rgb = r_border_rgb;
                default:    w_rgb = c_rgb_black;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= c_rgb_black;
            frame_start <= 1'b0;
        end else if (!en) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= c_rgb_black;
            frame_start <= 1'b0;
        end else begin
            hs          <= w_out_ctl.hs_on ? HS_POL : ~HS_POL;
            vs          <= w_out_ctl.vs_on ? VS_POL : ~VS_POL;
            de          <= w_out_ctl.de;
            rgb         <= w_rgb;
            frame_start <= w_out_ctl.fs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_tile_renderer
// Description : Directed bench for video_tile_renderer with RD_LAT=3 and a
//               shortened frame (V_ACTIVE=40, 54 lines of 525 pixels).
//               A model tile RAM returns 1 for every tile except (5,1).
//               Pixel k = v*525+h reaches the outputs after posedge k+4 and
//               the tile read for it after posedge k+1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_tile_renderer;

    localparam int c_rd_lat = 3;
    localparam int c_frame  = 54 * 525;

    logic        clk;
    logic        rst;
    logic        en;
    logic        outline_en;
    logic [23:0] fg_rgb;
    logic [23:0] bg_rgb;
    logic [23:0] border_rgb;
    logic [23:0] outline_rgb;
    logic        tile_rd_en;
    logic [11:0] tile_col;
    logic [11:0] tile_row;
    logic        tile_bit;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int pc     = 0;

    video_tile_renderer #(
        .V_ACTIVE (40),
        .RD_LAT   (c_rd_lat)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .outline_en  (outline_en),
        .fg_rgb      (fg_rgb),
        .bg_rgb      (bg_rgb),
        .border_rgb  (border_rgb),
        .outline_rgb (outline_rgb),
        .tile_rd_en  (tile_rd_en),
        .tile_col    (tile_col),
        .tile_row    (tile_row),
        .tile_bit    (tile_bit),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model tile RAM: combinational lookup plus RD_LAT-1 register stages.
    logic m_d1;
    logic m_d2;
    always @(posedge clk) begin
        m_d1 <= !((tile_col == 12'd5) && (tile_row == 12'd1));
        m_d2 <= m_d1;
    end
    assign tile_bit = m_d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        while (pc < n) begin
            @(posedge clk);
            pc++;
        end
        #1;
    endtask

    task automatic at_out(input int k); at_cyc(k + c_rd_lat + 1); endtask
    task automatic at_rd(input int k);  at_cyc(k + 1);            endtask

    function automatic int apx(input int ax, input int ay);
        return (ay + 12) * 525 + ax + 43;
    endfunction

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        outline_en  = 1'b1;
        fg_rgb      = 24'hFF8C00;
        bg_rgb      = 24'h202020;
        border_rgb  = 24'h0000FF;
        outline_rgb = 24'h000000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_rd", tile_rd_en, 0);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("en0_hs", hs, 1);
        chk("en0_de", de, 0);

        en = 1'b1;
        pc = 0;

        // Syncs and frame start
        at_out(0);
        chk("f1_fs", frame_start, 1);
        chk("f1_hs0", hs, 0);
        chk("f1_vs0", vs, 0);
        chk("f1_de0", de, 0);
        at_out(1);   chk("f1_fs_pulse", frame_start, 0);
        at_out(40);  chk("hs_low_40", hs, 0);
        at_out(41);  chk("hs_high_41", hs, 1);
        at_out(524); chk("hs_high_524", hs, 1);
        at_out(525); chk("hs_period", hs, 0);
        at_out(9 * 525);  chk("vs_low_line9", vs, 0);
        at_out(10 * 525); chk("vs_high_line10", vs, 1);

        // Active window
        at_out(apx(-1, 0)); chk("de_before", de, 0);
        at_out(apx(0, 0));  chk("de_first", de, 1);
        chk("rgb_outside", rgb, 0);

        // Above the border ring
        at_rd(apx(20, 13));  chk("rd_above", tile_rd_en, 0);
        at_out(apx(20, 13)); chk("rgb_above", rgb, 0);

        // Grid corner
        at_rd(apx(15, 16)); chk("rd_left_edge", tile_rd_en, 0);
        at_rd(apx(16, 16));
        chk("rd_first", tile_rd_en, 1);
        chk("col_first", tile_col, 0);
        chk("row_first", tile_row, 0);
        at_out(apx(16, 16)); chk("pix_16_16", rgb, 24'h000000);
        at_out(apx(17, 17)); chk("pix_17_17", rgb, 24'hFF8C00);

        // Horizontal border ring and grid right edge
        at_out(apx(13, 20));  chk("pix_13_20", rgb, 24'h000000);
        at_out(apx(14, 20));  chk("pix_14_20", rgb, 24'h0000FF);
        at_out(apx(463, 20)); chk("pix_463_20", rgb, 24'h000000);
        at_out(apx(464, 20)); chk("pix_464_20", rgb, 24'h0000FF);
        at_out(apx(466, 20)); chk("pix_466_20", rgb, 24'h000000);
        chk("de_466_20", de, 1);

        // Colour change mid-frame must not affect this frame
        at_out(apx(0, 30));
        fg_rgb     = 24'h00FF00;
        outline_en = 1'b0;
        at_out(apx(16, 33)); chk("hold_outline", rgb, 24'h000000);
        at_out(apx(17, 33)); chk("hold_fg", rgb, 24'hFF8C00);
        at_out(apx(99, 35)); chk("pix_bg_tile", rgb, 24'h202020);

        // Reads near the bottom (grid clipped by V_ACTIVE) and right edge
        at_rd(apx(69, 39));
        chk("rd_69_39", tile_rd_en, 1);
        chk("col_69_39", tile_col, 3);
        chk("row_69_39", tile_row, 1);
        at_rd(apx(464, 39)); chk("rd_past_grid", tile_rd_en, 0);

        // Second frame uses the new colour set
        at_out(c_frame);                 chk("f2_fs", frame_start, 1);
        at_out(c_frame + apx(16, 16));   chk("f2_pix_16_16", rgb, 24'h00FF00);
        at_out(c_frame + 30 * 525 + 10); chk("f2_hs_before_rst", hs, 0);

        // Asynchronous reset mid-frame
        rst = 1'b1;
        #1;
        chk("arst_hs", hs, 1);
        chk("arst_vs", vs, 1);
        chk("arst_rgb", rgb, 0);
        chk("arst_rd", tile_rd_en, 0);
        #2;
        rst = 1'b0;
        pc  = 0;
        at_cyc(c_rd_lat);
        chk("post_rst_fs_early", frame_start, 0);
        chk("post_rst_hs_early", hs, 1);
        at_out(0);
        chk("post_rst_fs", frame_start, 1);
        chk("post_rst_hs", hs, 0);
        chk("post_rst_vs", vs, 0);
        at_out(40); chk("post_rst_hs40", hs, 0);
        at_out(41); chk("post_rst_hs41", hs, 1);
        at_out(apx(17, 17)); chk("post_rst_pix", rgb, 24'h00FF00);

        // Enable drop forces idle outputs; restart counts from the origin
        at_out(apx(20, 20)); chk("de_before_en0", de, 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_off_de", de, 0);
        chk("en_off_rgb", rgb, 0);
        chk("en_off_rd", tile_rd_en, 0);
        chk("en_off_hs", hs, 1);
        en = 1'b1;
        pc = 0;
        at_out(0); chk("restart_fs", frame_start, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
